pgr_apb_regbank_32bit: RTL and testbench
========================================

PGR_APB_REGBANK_32BIT -- requirements
Module: pgr_apb_regbank_32bit

Interface
REQ-001 Parameter AW, default 16, APB address width in bits.
REQ-002 Parameter DW, default 32, APB data width in bits.
REQ-003 Parameter SW, default 4, APB byte-strobe width in bits.
REQ-004 Parameter WAIT_CYC, default 1, extra access-phase wait cycles; legal range 0..15.
REQ-005 Parameter ID_VAL, default 32'h5047_0001, value returned by the ID register.
REQ-006 i_clk  input  1  sole clock; all state changes on the rising edge.
REQ-007 i_rst_n  input  1  reset; synchronous, active-low.
REQ-008 i_p_sel  input  1  APB select.
REQ-009 i_p_enable  input  1  APB access-phase enable.
REQ-010 i_p_we  input  1  1 = write, 0 = read.
REQ-011 i_p_addr  input  AW  byte address; bits [1:0] are ignored.
REQ-012 i_p_strb  input  SW  write byte strobes; bit n enables byte n.
REQ-013 i_p_wdata  input  DW  write data.
REQ-014 o_p_ready  output  1  transfer-complete pulse.
REQ-015 o_p_rdata  output  DW  read data; valid only while o_p_ready is 1.
REQ-016 i_evt  input  8  event pulses that set STATUS bits.
REQ-017 o_ctrl  output  DW  current CTRL register contents.
REQ-018 o_addr_err  output  1  one-cycle pulse on a completed access to an unmapped address.

Function
REQ-019 Register map SHALL be: 0x00 ID (RO, ID_VAL); 0x04 CTRL (RW); 0x08 STATUS (bits [7:0] W1C, bits [31:8] read 0); 0x0C CNT (RO); 0x10/0x14/0x18/0x1C SCRATCH0..3 (RW).
REQ-020 Any address >= 0x20 SHALL be unmapped: reads return 0, writes have no effect, and o_addr_err pulses in the o_p_ready cycle.
REQ-021 FSM states SHALL be IDLE, SETUP and ACCESS.
REQ-022 FSM transitions: IDLE->SETUP on sel=1 with enable=0; SETUP->ACCESS on sel=1 with enable=1; SETUP->IDLE on sel=0; ACCESS->IDLE in the cycle after o_p_ready=1, or immediately on sel=0.
REQ-023 Access cycles SHALL be numbered from 0, where cycle 0 is the first cycle with sel=1 and enable=1; o_p_ready SHALL be 1 in access cycle WAIT_CYC+1 only and SHALL be a registered signal.
REQ-024 If sel drops during ACCESS, the FSM SHALL return to IDLE with no register commit, no o_p_ready and no o_addr_err.
REQ-025 A write SHALL commit on the clock edge that ends the o_p_ready cycle; for RW registers only bytes whose strobe bit is 1 SHALL be updated.
REQ-026 A write with strobe 0000 SHALL change nothing but still complete with o_p_ready.
REQ-027 STATUS: a 1 written to a bit (with its byte strobe set) SHALL clear that bit; an i_evt[n]=1 pulse SHALL set bit n; set SHALL win when set and clear occur in the same cycle.
REQ-028 CNT SHALL increment by 1 every cycle, wrap from 32'hFFFF_FFFF to 0, and ignore writes.
REQ-029 o_p_rdata SHALL be 0 whenever o_p_ready is 0.
REQ-030 Read data SHALL be sampled at the o_p_ready cycle; CNT reads return the value at that cycle.
REQ-031 o_ctrl SHALL reflect a CTRL write in the cycle after the commit.

Reset
REQ-032 While i_rst_n=0 at a clock edge: FSM SHALL go to IDLE; CTRL, STATUS, CNT and SCRATCH0..3 SHALL go to 0; o_p_ready, o_p_rdata and o_addr_err SHALL go to 0.
REQ-033 A reset during ACCESS SHALL abort the transfer with no commit; the first edge with i_rst_n=1 leaves CNT=0.

Verification
REQ-034 Write CTRL=32'hA5A5_1234 with strobe 1111, WAIT_CYC=1 -> o_p_ready in access cycle 2; o_ctrl=32'hA5A5_1234 one cycle later.
REQ-035 Write SCRATCH1 (preset 32'h1111_1111) with wdata 32'hFFFF_FFFF and strobe 0101 -> readback 32'h11FF_11FF.
REQ-036 Pulse i_evt=8'h0F, then write STATUS=8'h03 in the same cycle as an i_evt[1] pulse -> readback 8'h0E.
REQ-037 Read address 0x40 -> o_p_rdata=0 and o_addr_err=1 in the o_p_ready cycle; no register changes.
REQ-038 Drop sel in access cycle 0 of a CTRL write -> no o_p_ready and CTRL unchanged; then read ID -> 32'h5047_0001.
REQ-039 Assert reset during a SCRATCH0 write in ACCESS -> all outputs 0; a subsequent SCRATCH0 read returns 0.

Source files
------------

// File: rtl/pgr_apb_regbank_32bit_if.sv
// APB bus bundle for pgr_apb_regbank_32bit.
//   i_p_sel, i_p_enable, i_p_we : APB select, access-phase enable, direction
//   i_p_addr [AW]               : byte address (bits [1:0] ignored by the slave)
//   i_p_strb [SW]               : write byte strobes
//   i_p_wdata [DW]              : write data
//   o_p_ready                   : transfer-complete pulse (slave driven)
//   o_p_rdata [DW]              : read data, valid only with o_p_ready
interface pgr_apb_regbank_32bit_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 32,
  parameter int unsigned SW = 4
);
  logic          i_p_sel;
  logic          i_p_enable;
  logic          i_p_we;
  logic [AW-1:0] i_p_addr;
  logic [SW-1:0] i_p_strb;
  logic [DW-1:0] i_p_wdata;
  logic          o_p_ready;
  logic [DW-1:0] o_p_rdata;

  modport master (
    output i_p_sel, i_p_enable, i_p_we, i_p_addr, i_p_strb, i_p_wdata,
    input  o_p_ready, o_p_rdata
  );

  modport slave (
    input  i_p_sel, i_p_enable, i_p_we, i_p_addr, i_p_strb, i_p_wdata,
    output o_p_ready, o_p_rdata
  );
endinterface

// File: rtl/pgr_apb_regbank_32bit.sv
// APB register bank: ID, CTRL, STATUS (W1C event flags), free-running CNT
// and four scratch registers, with a configurable number of wait cycles.
//   i_clk      : clock, all state on the rising edge
//   i_rst_n    : synchronous active-low reset
//   apb        : APB slave bus (see pgr_apb_regbank_32bit_if)
//   i_evt [8]  : event pulses that set STATUS bits
//   o_ctrl     : current CTRL register
//   o_addr_err : pulse in the ready cycle of an access to an unmapped address
// Map: 0x00 ID, 0x04 CTRL, 0x08 STATUS, 0x0C CNT, 0x10..0x1C SCRATCH0..3.
module pgr_apb_regbank_32bit #(
  parameter int unsigned   AW       = 16,
  parameter int unsigned   DW       = 32,
  parameter int unsigned   SW       = 4,
  parameter int unsigned   WAIT_CYC = 1,
  parameter logic [DW-1:0] ID_VAL   = 32'h5047_0001
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  pgr_apb_regbank_32bit_if.slave        apb,
  input  logic [7:0]                    i_evt,
  output logic [DW-1:0]                 o_ctrl,
  output logic                          o_addr_err
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state_q, state_d;
  logic [4:0]    idx_q, idx_d;      // index of the current access cycle
  logic          ready_q, ready_d;
  logic          err_q, err_d;

  logic [DW-1:0] ctrl_q;
  logic [DW-1:0] cnt_q;
  logic [DW-1:0] scr_q [4];
  logic [7:0]    status_q;
  logic          run_q;             // holds CNT at 0 for the first edge out of reset

  logic          unmapped;
  logic [2:0]    word;
  logic          commit;
  logic [7:0]    status_clr;
  logic [DW-1:0] rd_word;
  logic          unused_addr_lsb;

  assign unmapped        = |apb.i_p_addr[AW-1:5];
  assign word            = apb.i_p_addr[4:2];
  assign unused_addr_lsb = ^apb.i_p_addr[1:0];

  // Write lands on the edge that closes the ready cycle.
  assign commit = ready_q && apb.i_p_sel && apb.i_p_we && !unmapped;

  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_v,
                                               input logic [DW-1:0] new_v,
                                               input logic [SW-1:0] strb);
    logic [DW-1:0] r;
    r = old_v;
    for (int unsigned b = 0; b < SW; b++)
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Ready is registered: it is decided in access cycle WAIT_CYC so that it
  // shows in access cycle WAIT_CYC+1. With WAIT_CYC=0 that decision happens
  // while still in SETUP (access cycle 0).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (apb.i_p_sel && !apb.i_p_enable) state_d = SETUP;
      end
      SETUP: begin
        if (!apb.i_p_sel) begin
          state_d = IDLE;
        end else if (apb.i_p_enable) begin
          state_d = ACCESS;
          idx_d   = 5'd1;
          if (WAIT_CYC == 0) begin
            ready_d = 1'b1;
            err_d   = unmapped;
          end
        end
      end
      ACCESS: begin
        if (!apb.i_p_sel || ready_q) begin
          state_d = IDLE;
        end else if (apb.i_p_enable) begin
          idx_d = idx_q + 5'd1;
          if (idx_q == 5'(WAIT_CYC)) begin
            ready_d = 1'b1;
            err_d   = unmapped;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign status_clr = (commit && word == 3'd2 && apb.i_p_strb[0]) ? apb.i_p_wdata[7:0] : '0;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ctrl_q   <= '0;
      cnt_q    <= '0;
      status_q <= '0;
      run_q    <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) scr_q[i] <= '0;
    end else begin
      run_q <= 1'b1;
      if (run_q) cnt_q <= cnt_q + 1'b1;
      // Event set takes priority over a simultaneous W1C clear.
      status_q <= (status_q & ~status_clr) | i_evt;
      if (commit) begin
        case (word)
          3'd1:                   ctrl_q          <= apply_strb(ctrl_q, apb.i_p_wdata, apb.i_p_strb);
          3'd4, 3'd5, 3'd6, 3'd7: scr_q[word[1:0]] <= apply_strb(scr_q[word[1:0]], apb.i_p_wdata, apb.i_p_strb);
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_word = '0;
    case (word)
      3'd0:    rd_word = ID_VAL;
      3'd1:    rd_word = ctrl_q;
      3'd2:    rd_word = {{(DW-8){1'b0}}, status_q};
      3'd3:    rd_word = cnt_q;
      default: rd_word = scr_q[word[1:0]];
    endcase
  end

  assign apb.o_p_ready = ready_q;
  assign apb.o_p_rdata = (ready_q && !apb.i_p_we && !unmapped) ? rd_word : '0;
  assign o_ctrl        = ctrl_q;
  assign o_addr_err    = err_q;

endmodule

// File: tb/tb_pgr_apb_regbank_32bit.sv
module tb_pgr_apb_regbank_32bit;
  localparam int WAIT_CYC = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  evt;
  logic [31:0] ctrl;
  logic        addr_err;

  pgr_apb_regbank_32bit_if #(.AW(16), .DW(32), .SW(4)) bus ();

  pgr_apb_regbank_32bit #(
    .AW(16), .DW(32), .SW(4), .WAIT_CYC(WAIT_CYC), .ID_VAL(32'h5047_0001)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .apb(bus.slave),
    .i_evt(evt), .o_ctrl(ctrl), .o_addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: register contents by the register-map rules.
  logic [31:0] m_ctrl, m_cnt;
  logic [31:0] m_scr [4];
  logic [7:0]  m_status;
  bit          m_run;
  bit          exp_ready, exp_err;
  logic [31:0] exp_rdata;
  bit          chk_en = 0;
  bit          rnd_evt = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                            input logic [3:0] strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [15:0] a);
    if (a >= 16'h20) return 32'h0;
    case (a[4:2])
      3'd0:    return 32'h5047_0001;
      3'd1:    return m_ctrl;
      3'd2:    return {24'h0, m_status};
      3'd3:    return m_cnt;
      default: return m_scr[a[3:2]];
    endcase
  endfunction

  task automatic model_edge();
    logic [7:0] clr;
    if (!rst_n) begin
      m_ctrl = '0; m_status = '0; m_cnt = '0; m_run = 0;
      for (int i = 0; i < 4; i++) m_scr[i] = '0;
    end else begin
      clr = '0;
      if (exp_ready && bus.i_p_we && bus.i_p_addr < 16'h20) begin
        case (bus.i_p_addr[4:2])
          3'd1: m_ctrl = byte_merge(m_ctrl, bus.i_p_wdata, bus.i_p_strb);
          3'd2: if (bus.i_p_strb[0]) clr = bus.i_p_wdata[7:0];
          3'd4, 3'd5, 3'd6, 3'd7:
                m_scr[bus.i_p_addr[3:2]] = byte_merge(m_scr[bus.i_p_addr[3:2]], bus.i_p_wdata, bus.i_p_strb);
          default: ;
        endcase
      end
      m_status = (m_status & ~clr) | evt;
      if (m_run) m_cnt = m_cnt + 1;
      m_run = 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [7:0] rand_evt();
    if (rnd_evt && $urandom_range(0, 3) == 0) return 8'($urandom);
    return 8'h00;
  endfunction

  task automatic set_exp_idle();
    exp_ready = 0; exp_err = 0; exp_rdata = '0;
  endtask

  // Single compare process: outputs against the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("p_ready", {31'h0, bus.o_p_ready}, {31'h0, exp_ready});
      check("p_rdata", bus.o_p_rdata, exp_rdata);
      check("addr_err", {31'h0, addr_err}, {31'h0, exp_err});
      check("ctrl", ctrl, m_ctrl);
    end
  end

  task automatic idle_cycle();
    bus.i_p_sel = 0; bus.i_p_enable = 0;
    evt = rand_evt();
    set_exp_idle();
    @(negedge clk);
    step();
  endtask

  // One APB transfer. abort_at / rst_at: access-cycle index where sel drops
  // or reset is asserted (-1 for none). Returns the access-cycle index in
  // which the DUT showed ready (-1 if never) with its rdata / addr_err.
  task automatic xfer(input bit we, input logic [15:0] addr, input logic [3:0] strb,
                      input logic [31:0] wdata, input int abort_at, input int rst_at,
                      input logic [7:0] evt_rdy, output int rdy_at,
                      output logic [31:0] rd, output logic err);
    rdy_at = -1; rd = '0; err = 0;
    bus.i_p_sel = 1; bus.i_p_enable = 0; bus.i_p_we = we;
    bus.i_p_addr = addr; bus.i_p_strb = strb; bus.i_p_wdata = wdata;
    evt = rand_evt();
    set_exp_idle();
    @(negedge clk);
    step();
    for (int k = 0; k <= WAIT_CYC + 1; k++) begin
      bus.i_p_enable = 1;
      evt = rand_evt();
      set_exp_idle();
      if (k == abort_at) begin
        bus.i_p_sel = 0; bus.i_p_enable = 0;
        @(negedge clk);
        step();
        break;
      end
      if (k == rst_at) begin
        rst_n = 0;
        @(negedge clk);
        step();
        break;
      end
      if (k == WAIT_CYC + 1) begin
        exp_ready = 1;
        exp_err   = (addr >= 16'h20);
        exp_rdata = we ? 32'h0 : model_read(addr);
        evt       = evt | evt_rdy;
      end
      @(negedge clk);
      if (bus.o_p_ready && rdy_at < 0) begin
        rdy_at = k; rd = bus.o_p_rdata; err = addr_err;
      end
      step();
    end
    bus.i_p_sel = 0; bus.i_p_enable = 0; evt = 8'h00;
    set_exp_idle();
  endtask

  initial begin
    int          rdy;
    logic [31:0] rd, rd2;
    logic        e;
    int          w, ab;
    logic [15:0] a;

    rst_n = 0; evt = 8'h00;
    bus.i_p_sel = 0; bus.i_p_enable = 0; bus.i_p_we = 0;
    bus.i_p_addr = '0; bus.i_p_strb = '0; bus.i_p_wdata = '0;
    set_exp_idle();
    repeat (3) step();
    chk_en = 1;
    check("reset_ctrl", ctrl, 32'h0);
    check("reset_ready", {31'h0, bus.o_p_ready}, 32'h0);
    check("reset_err", {31'h0, addr_err}, 32'h0);
    rst_n = 1;
    idle_cycle();

    xfer(0, 16'h0000, 4'h0, 32'h0, -1, -1, 8'h00, rdy, rd, e);
    check("id_read", rd, 32'h5047_0001);

    // CTRL write: ready in access cycle 2, o_ctrl updated on the next cycle
    xfer(1, 16'h0004, 4'hF, 32'hA5A5_1234, -1, -1, 8'h00, rdy, rd, e);
    check("ctrl_ready_cycle", rdy, 2);
    check("ctrl_out", ctrl, 32'hA5A5_1234);

    // SCRATCH1 partial write
    xfer(1, 16'h0014, 4'hF, 32'h1111_1111, -1, -1, 8'h00, rdy, rd, e);
    xfer(1, 16'h0014, 4'h5, 32'hFFFF_FFFF, -1, -1, 8'h00, rdy, rd, e);
    xfer(0, 16'h0014, 4'h0, 32'h0, -1, -1, 8'h00, rdy, rd, e);
    check("scr1_strb", rd, 32'h11FF_11FF);

    // STATUS: set 0F, clear 03 while event bit 1 fires again
    bus.i_p_sel = 0; bus.i_p_enable = 0; evt = 8'h0F; set_exp_idle();
    @(negedge clk); step();
    evt = 8'h00;
    xfer(1, 16'h0008, 4'h1, 32'h0000_0003, -1, -1, 8'h02, rdy, rd, e);
    xfer(0, 16'h0008, 4'h0, 32'h0, -1, -1, 8'h00, rdy, rd, e);
    check("status_w1c", rd, 32'h0000_000E);

    // Unmapped read
    xfer(0, 16'h0040, 4'h0, 32'h0, -1, -1, 8'h00, rdy, rd, e);
    check("unmapped_rdata", rd, 32'h0);
    check("unmapped_err", {31'h0, e}, 32'h1);
    xfer(0, 16'h0004, 4'h0, 32'h0, -1, -1, 8'h00, rdy, rd, e);
    check("ctrl_after_unmapped", rd, 32'hA5A5_1234);

    // Aborted CTRL writes, then ID read
    xfer(1, 16'h0004, 4'hF, 32'h0BAD_0BAD, 0, -1, 8'h00, rdy, rd, e);
    check("abort0_no_ready", rdy, -1);
    xfer(1, 16'h0004, 4'hF, 32'h0BAD_0BAD, 1, -1, 8'h00, rdy, rd, e);
    check("abort1_no_ready", rdy, -1);
    check("abort_ctrl_kept", ctrl, 32'hA5A5_1234);
    xfer(0, 16'h0000, 4'h0, 32'h0, -1, -1, 8'h00, rdy, rd, e);
    check("id_after_abort", rd, 32'h5047_0001);

    // Zero-strobe write completes without changing CTRL
    xfer(1, 16'h0004, 4'h0, 32'hFFFF_FFFF, -1, -1, 8'h00, rdy, rd, e);
    check("strb0_ready", rdy, 2);
    check("strb0_ctrl", ctrl, 32'hA5A5_1234);

    // Back-to-back CNT reads are 4 cycles apart
    xfer(0, 16'h000C, 4'h0, 32'h0, -1, -1, 8'h00, rdy, rd, e);
    xfer(0, 16'h000C, 4'h0, 32'h0, -1, -1, 8'h00, rdy, rd2, e);
    check("cnt_delta", rd2 - rd, 32'd4);

    // Reset in the middle of a SCRATCH0 write
    xfer(1, 16'h0010, 4'hF, 32'hDEAD_BEEF, -1, -1, 8'h00, rdy, rd, e);
    xfer(1, 16'h0010, 4'hF, 32'h1234_5678, -1, 1, 8'h00, rdy, rd, e);
    check("rst_ctrl", ctrl, 32'h0);
    check("rst_ready", {31'h0, bus.o_p_ready}, 32'h0);
    check("rst_rdata", bus.o_p_rdata, 32'h0);
    check("rst_err", {31'h0, addr_err}, 32'h0);
    rst_n = 1;
    xfer(0, 16'h000C, 4'h0, 32'h0, -1, -1, 8'h00, rdy, rd, e);
    check("cnt_after_rst", rd, 32'd2);
    xfer(0, 16'h0010, 4'h0, 32'h0, -1, -1, 8'h00, rdy, rd, e);
    check("scr0_after_rst", rd, 32'h0);

    // Randomized traffic against the model
    rnd_evt = 1;
    for (int t = 0; t < 120; t++) begin
      w = $urandom_range(0, 9);
      if (w < 8) a = 16'(w * 4 + $urandom_range(0, 3));
      else       a = 16'($urandom_range(32, 65535));
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, WAIT_CYC) : -1;
      xfer(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, ab, -1, 8'h00, rdy, rd, e);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end
    rnd_evt = 0;
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
